mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle control unit for the ARM-subset processor: sequences the shared-memory datapath over 2-5 states/instr.
//  Covers fetch, decode, memory address, memory read/write, write-back, execute and branch, with NZCV flags and condition check.
//  Sits between the instruction register (Cond/Op/Funct/Rd) and datapath muxes and enables. Replaces the single-cycle decode path.
// PARAMETERS
//  FLAGS_RST  4'b0000  NZCV value loaded on reset
// PORTS
//  clk         in   1  system clock, rising edge
//  reset       in   1  synchronous, active-high
//  Cond        in   4  Instr[31:28]
//  Op          in   2  Instr[27:26]
//  Funct       in   6  Instr[25:20]
//  Rd          in   4  Instr[15:12]
//  ALUFlags    in   4  NZCV from ALU, current cycle
//  IRWrite     out  1  instruction register enable
//  AdrSrc      out  1  memory address: 0=PC, 1=ALUOut
//  ALUSrcA     out  1  0=RD1(A), 1=PC
//  ALUSrcB     out  2  00=RD2, 01=ExtImm, 10=const 4
//  ResultSrc   out  2  00=ALUOut, 01=Data, 10=ALUResult
//  ImmSrc      out  2  = Op (combinational)
//  RegSrc      out  2  [0]=(Op==10), [1]=(Op==01)
//  ALUControl  out  3  000 ADD,001 SUB,010 AND,011 ORR,100 shift
//  PCWrite     out  1  PC register enable
//  RegWrite    out  1  register file write enable
//  MemWrite    out  1  data memory write enable
//  BrL         out  1  link write: WA3=R14, WD3=PC
//  Illegal     out  1  1-cycle pulse on unimplemented Op
//  state_dbg   out  4  current state encoding
// BEHAVIOUR
//  Reset: state=FETCH(0), Flags=FLAGS_RST, CondExR=0; during reset, all enables (IRWrite,PCWrite,RegWrite,MemWrite,BrL,Illegal)=0.
//  Reset mid-instruction aborts it; no writes occur in the reset cycle. Fetch restarts the cycle after reset deasserts.
//  States: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXECR6 EXECI7 ALUWB8 BRANCH9. Codes 10-15 -> FETCH.
//  Transitions: FETCH->DECODE. From DECODE:
//    Op=01 -> MEMADR. MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
//    Op=00, Funct[4:0]=10010 (NOP) -> FETCH.
//    Op=00 otherwise: Funct[5]=1 -> EXECI, else EXECR.
//    Op=10 -> BRANCH.
//    Op=11 -> FETCH, with Illegal=1.
//  MEMRD->MEMWB->FETCH. MEMWR->FETCH. EXECR/EXECI->ALUWB->FETCH. BRANCH->FETCH.
//  Latency (cycles): LDR 5, STR 4, DP 4, B/BL 3, NOP/illegal 2. Timing is the same whether or not the condition passes.
//  Per-state raw controls (unlisted = 0 / 00):
//    FETCH:  IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1.
//    DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
//    MEMADR: ALUSrcB=01.
//    MEMRD:  AdrSrc=1.
//    MEMWB:  ResultSrc=01, RegW=1.
//    MEMWR:  AdrSrc=1, MemW=1.
//    EXECR:  ALUOp=1.
//    EXECI:  ALUSrcB=01, ALUOp=1.
//    ALUWB:  RegW=1.
//    BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1, RegW=Funct[4], BrL=Funct[4].
//  ALU decode (ALUOp=1), on Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1101 shift, else 000.
//  ALUOp=0 -> ADD.
//  FlagW[1] (NZ) = ALUOp & Funct[0]. FlagW[0] (CV) = FlagW[1] & ALUControl is ADD or SUB.
//  Condition check: CondEx is computed combinationally in DECODE from Cond and Flags, then registered into CondExR for the rest of the instruction.
//    EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
//    HI C&!Z; LS !(C&!Z); GE N==V; LT N!=V; GT !Z&(N==V); LE !(!Z&(N==V)).
//    AL(1110)=1; 1111=0.
//  Gated outputs:
//    PCWrite  = NextPC | (Branch & CondExR) | (ALUWB|MEMWB)&(Rd==15)&CondExR.
//    RegWrite = RegW & CondExR & !(Rd==15 & !BRANCH).
//    MemWrite = MemW & CondExR.
//    BrL output = BrL & CondExR.
//  Flags: NZ <= ALUFlags[3:2] when FlagW[1] & CondExR; CV <= ALUFlags[1:0] when FlagW[0] & CondExR. Updates happen only in EXECR/EXECI.
//  Flags written by instruction k are visible to the CondEx of instruction k+1 (DECODE follows the write).
//  ImmSrc, RegSrc and ALUControl are valid in every state. All enables are glitch-free decodes of registered state.
// TESTING
//  Hold reset 2 cycles in MEMRD -> state_dbg=0 and all enables 0; after release: IRWrite=1, PCWrite=1 in the first cycle.
//  ADDS R1 (Cond=1110, Op=00, Funct=101001), ALUFlags=0100 in EXECI -> states 0,1,7,8; RegWrite=1 in ALUWB only; Flags=0100.
//  LDR (Op=01, Funct=011001, AL) -> states 0,1,2,3,4; AdrSrc=1 in MEMRD; RegWrite=1, ResultSrc=01 in MEMWB.
//  STR with Cond=0000, Flags Z=0 -> 4 cycles, MemWrite=0 throughout. Repeat with Z=1 -> MemWrite=1 in MEMWR.
//  BL AL (Op=10, Funct=010000) -> BRANCH: PCWrite=1, RegWrite=1, BrL=1. BEQ with Z=0 -> PCWrite=0 in BRANCH.
//  Op=11 -> Illegal pulse in DECODE, back to FETCH; SUB Rd=15 AL -> PCWrite=1, RegWrite=0 in ALUWB.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Bundles the instruction-field and ALU-flag inputs with the datapath control outputs
// of the multicycle control unit. The master side is the instruction register and ALU
// (the testbench stands in for them). The slave side is the control FSM.
interface mc_control_fsm_if;
  // Instruction fields and ALU flags
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;

  // Datapath controls
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [2:0] ALUControl;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       BrL;
  logic       Illegal;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
           ALUControl, PCWrite, RegWrite, MemWrite, BrL, Illegal
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
           ALUControl, PCWrite, RegWrite, MemWrite, BrL, Illegal
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the ARM-subset processor. It steps the shared-memory
// datapath through fetch, decode, memory, execute, write-back and branch states.
// It keeps the NZCV flags. It evaluates the condition field once in DECODE and holds
// the result in cond_ex_q for the rest of the instruction. Every write enable is a
// decode of registered state, gated by that held result and forced low during reset.
module mc_control_fsm #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic               clk,
  input  logic               reset,
  mc_control_fsm_if.slave    bus,
  output logic [3:0]         state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;

  // Raw per-state controls, before condition gating
  logic       next_pc, branch, reg_w, mem_w, brl_raw, alu_op, ir_write_raw, illegal_raw;
  logic       adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src;
  logic [2:0] alu_control;
  logic [1:0] flag_w;
  logic       cond_ex;
  logic       rd_is_pc;

  assign rd_is_pc  = (bus.Rd == 4'd15);
  assign state_dbg = state_q;

  // State, flags and held condition result; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      flags_q   <= FLAGS_RST;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  // Next-state logic and raw per-state control decode
  always_comb begin
    state_d      = S_FETCH;
    next_pc      = 1'b0;
    branch       = 1'b0;
    reg_w        = 1'b0;
    mem_w        = 1'b0;
    brl_raw      = 1'b0;
    alu_op       = 1'b0;
    ir_write_raw = 1'b0;
    illegal_raw  = 1'b0;
    adr_src      = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    result_src   = 2'b00;
    case (state_q)
      S_FETCH: begin
        state_d      = S_DECODE;
        ir_write_raw = 1'b1;
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        next_pc      = 1'b1;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (bus.Op)
          2'b01: state_d = S_MEMADR;
          2'b00: begin
            if (bus.Funct[4:0] == 5'b10010) state_d = S_FETCH;
            else if (bus.Funct[5])          state_d = S_EXECI;
            else                            state_d = S_EXECR;
          end
          2'b10: state_d = S_BRANCH;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_EXECR: begin
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
        reg_w      = bus.Funct[4];
        brl_raw    = bus.Funct[4];
      end
      default: state_d = S_FETCH;
    endcase
  end

  // ALU operation select and flag-write enables
  always_comb begin
    alu_control = 3'b000;
    if (alu_op) begin
      case (bus.Funct[4:1])
        4'b0100: alu_control = 3'b000;
        4'b0010: alu_control = 3'b001;
        4'b0000: alu_control = 3'b010;
        4'b1100: alu_control = 3'b011;
        4'b1101: alu_control = 3'b100;
        default: alu_control = 3'b000;
      endcase
    end
    flag_w[1] = alu_op & bus.Funct[0];
    flag_w[0] = flag_w[1] & ((alu_control == 3'b000) | (alu_control == 3'b001));
  end

  // Condition check against current flags (N=3, Z=2, C=1, V=0)
  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~(flags_q[1] & ~flags_q[2]);
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = ~(~flags_q[2] & (flags_q[3] == flags_q[0]));
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Latch the condition result in DECODE; update flags only when the instruction executes
  always_comb begin
    cond_ex_d = (state_q == S_DECODE) ? cond_ex : cond_ex_q;
    flags_d   = flags_q;
    if (flag_w[1] & cond_ex_q) flags_d[3:2] = bus.ALUFlags[3:2];
    if (flag_w[0] & cond_ex_q) flags_d[1:0] = bus.ALUFlags[1:0];
  end

  // Ungated mux selects
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {(bus.Op == 2'b01), (bus.Op == 2'b10)};
  assign bus.ALUControl = alu_control;

  // Enables: gated by the held condition result and forced low while reset is high
  assign bus.IRWrite  = ir_write_raw & ~reset;
  assign bus.PCWrite  = ~reset & (next_pc | (branch & cond_ex_q) |
                        (((state_q == S_ALUWB) | (state_q == S_MEMWB)) & rd_is_pc & cond_ex_q));
  assign bus.RegWrite = ~reset & reg_w & cond_ex_q & ~(rd_is_pc & (state_q != S_BRANCH));
  assign bus.MemWrite = ~reset & mem_w & cond_ex_q;
  assign bus.BrL      = ~reset & brl_raw & cond_ex_q;
  assign bus.Illegal  = ~reset & illegal_raw;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks instruction classes through the FSM and
// checks states and gated controls against hand-computed values.
module tb_mc_control_fsm;
  logic       clk;
  logic       reset;
  logic [3:0] state_dbg;
  int         checks;
  int         failures;

  mc_control_fsm_if intf ();

  mc_control_fsm #(.FLAGS_RST(4'b0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (intf.slave),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle, then settle away from the active edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic instr(input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [3:0] r);
    intf.Cond  = c;
    intf.Op    = o;
    intf.Funct = f;
    intf.Rd    = r;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    intf.ALUFlags = 4'b0000;
    instr(4'b1110, 2'b00, 6'b000000, 4'd0);

    // Reset: FETCH with enables held low
    tick();
    chk("rst_state", state_dbg, 0);
    chk("rst_irwrite", intf.IRWrite, 0);
    chk("rst_pcwrite", intf.PCWrite, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rel_irwrite", intf.IRWrite, 1);
    chk("rel_pcwrite", intf.PCWrite, 1);
    chk("rel_alusrcb", intf.ALUSrcB, 2'b10);

    // STR EQ with Z=0: condition fails, no memory write, 4 cycles
    instr(4'b0000, 2'b01, 6'b011000, 4'd3);
    tick(); chk("streq0_decode", state_dbg, 1);
    tick(); chk("streq0_memadr", state_dbg, 2);
    chk("streq0_alusrcb", intf.ALUSrcB, 2'b01);
    tick(); chk("streq0_memwr", state_dbg, 5);
    chk("streq0_memwrite", intf.MemWrite, 0);
    chk("streq0_adrsrc", intf.AdrSrc, 1);
    tick(); chk("streq0_back_fetch", state_dbg, 0);

    // ADDS R1 immediate, ALU reports Z -> flags become 0100
    instr(4'b1110, 2'b00, 6'b101001, 4'd1);
    tick(); chk("adds_decode", state_dbg, 1);
    tick(); chk("adds_execi", state_dbg, 7);
    chk("adds_aluctl", intf.ALUControl, 3'b000);
    chk("adds_execi_regwrite", intf.RegWrite, 0);
    intf.ALUFlags = 4'b0100;
    tick(); chk("adds_aluwb", state_dbg, 8);
    chk("adds_aluwb_regwrite", intf.RegWrite, 1);
    chk("adds_aluwb_pcwrite", intf.PCWrite, 0);
    intf.ALUFlags = 4'b0000;
    tick(); chk("adds_fetch", state_dbg, 0);
    chk("adds_fetch_regwrite", intf.RegWrite, 0);

    // STR EQ with Z=1: memory write in MEMWR
    instr(4'b0000, 2'b01, 6'b011000, 4'd3);
    tick(); tick(); tick();
    chk("streq1_memwr", state_dbg, 5);
    chk("streq1_memwrite", intf.MemWrite, 1);
    tick(); chk("streq1_fetch", state_dbg, 0);

    // LDR AL: 0,1,2,3,4
    instr(4'b1110, 2'b01, 6'b011001, 4'd2);
    tick(); chk("ldr_decode", state_dbg, 1);
    chk("ldr_regsrc", intf.RegSrc, 2'b10);
    tick(); chk("ldr_memadr", state_dbg, 2);
    tick(); chk("ldr_memrd", state_dbg, 3);
    chk("ldr_adrsrc", intf.AdrSrc, 1);
    chk("ldr_memrd_regwrite", intf.RegWrite, 0);
    tick(); chk("ldr_memwb", state_dbg, 4);
    chk("ldr_memwb_regwrite", intf.RegWrite, 1);
    chk("ldr_memwb_resultsrc", intf.ResultSrc, 2'b01);
    chk("ldr_memwb_pcwrite", intf.PCWrite, 0);
    tick(); chk("ldr_fetch", state_dbg, 0);

    // Reset held 2 cycles while an LDR sits in MEMRD (also clears flags to 0000)
    tick(); tick(); tick();
    chk("midrst_memrd", state_dbg, 3);
    reset = 1'b1;
    #1;
    chk("midrst_c0_adrsrc_regwrite", {intf.RegWrite, intf.PCWrite, intf.MemWrite}, 3'b000);
    tick();
    chk("midrst_c1_state", state_dbg, 0);
    chk("midrst_c1_enables", {intf.IRWrite, intf.PCWrite, intf.RegWrite,
                              intf.MemWrite, intf.BrL, intf.Illegal}, 6'b0);
    tick();
    chk("midrst_c2_state", state_dbg, 0);
    reset = 1'b0;
    #1;
    chk("midrst_rel_irwrite", intf.IRWrite, 1);
    chk("midrst_rel_pcwrite", intf.PCWrite, 1);

    // BL AL: link write and PC update in BRANCH
    instr(4'b1110, 2'b10, 6'b010000, 4'd0);
    tick(); chk("bl_decode", state_dbg, 1);
    chk("bl_immsrc", intf.ImmSrc, 2'b10);
    chk("bl_regsrc", intf.RegSrc, 2'b01);
    tick(); chk("bl_branch", state_dbg, 9);
    chk("bl_pcwrite", intf.PCWrite, 1);
    chk("bl_regwrite", intf.RegWrite, 1);
    chk("bl_brl", intf.BrL, 1);
    tick(); chk("bl_fetch", state_dbg, 0);

    // BEQ with Z=0: branch not taken, same timing
    instr(4'b0000, 2'b10, 6'b000000, 4'd0);
    tick(); tick();
    chk("beq0_branch", state_dbg, 9);
    chk("beq0_pcwrite", intf.PCWrite, 0);
    chk("beq0_regwrite_brl", {intf.RegWrite, intf.BrL}, 2'b00);
    tick(); chk("beq0_fetch", state_dbg, 0);

    // ADDS EQ with Z=0: condition fails, flags must stay clear
    instr(4'b0000, 2'b00, 6'b101001, 4'd1);
    tick(); tick();
    chk("addseq_execi", state_dbg, 7);
    intf.ALUFlags = 4'b0100;
    tick(); chk("addseq_regwrite", intf.RegWrite, 0);
    intf.ALUFlags = 4'b0000;
    tick();
    instr(4'b0000, 2'b10, 6'b000000, 4'd0);
    tick(); tick();
    chk("beq_after_skipped_adds_pcwrite", intf.PCWrite, 0);
    tick();

    // Illegal opcode: pulse in DECODE, back to FETCH
    instr(4'b1110, 2'b11, 6'b000000, 4'd0);
    chk("ill_fetch_pulse", intf.Illegal, 0);
    tick(); chk("ill_decode", state_dbg, 1);
    chk("ill_pulse", intf.Illegal, 1);
    tick(); chk("ill_fetch", state_dbg, 0);
    chk("ill_after", intf.Illegal, 0);

    // NOP: DECODE straight back to FETCH
    instr(4'b1110, 2'b00, 6'b010010, 4'd0);
    tick(); chk("nop_decode", state_dbg, 1);
    tick(); chk("nop_fetch", state_dbg, 0);

    // SUB Rd=15 AL: PC write instead of register write
    instr(4'b1110, 2'b00, 6'b000100, 4'd15);
    tick(); tick();
    chk("subpc_execr", state_dbg, 6);
    chk("subpc_aluctl", intf.ALUControl, 3'b001);
    tick(); chk("subpc_aluwb", state_dbg, 8);
    chk("subpc_pcwrite", intf.PCWrite, 1);
    chk("subpc_regwrite", intf.RegWrite, 0);
    tick();

    // ORR register form: ALU decode
    instr(4'b1110, 2'b00, 6'b011000, 4'd4);
    tick(); tick();
    chk("orr_execr", state_dbg, 6);
    chk("orr_aluctl", intf.ALUControl, 3'b011);
    tick(); chk("orr_regwrite", intf.RegWrite, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
